pass_arbiter: RTL and testbench

Shares one registered pass lane between NUM_REQ requesters. The lane has one flop of latency per beat. Round-robin arbitration uses valid/ready handshakes. A requester holds the lane for a multi-beat burst until it signals last or MAX_BURST beats elapse. The block sits in front of the pass datapath in the e2e flow and sequences which source drives it each cycle.

---
 rtl/pass_arb_pkg.sv | 19 +
 rtl/pass_rr_pick.sv | 36 +++
 rtl/pass_arbiter.sv | 102 ++++++++++
 tb/tb_pass_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pass_arb_pkg.sv
// Shared types and width helpers for the pass lane arbiter.
package pass_arb_pkg;

  // Grant FSM encoding
  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t LOCKED = 1'b1;

  // Width of a requester index; one bit minimum so a port always exists
  function automatic int src_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold values 0..max_burst inclusive
  function automatic int cnt_w(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/pass_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module pass_rr_pick
  import pass_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = src_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan ptr, ptr+1, ... mod N and latch the first hit
  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        grant[jj] = 1'b1;
        idx       = jj;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pass_arbiter.sv
// Round-robin, burst-locking arbiter feeding one registered pass lane.
module pass_arbiter
  import pass_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 8,
  localparam int SRC_W     = src_w(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic                      out_last,
  input  logic                      out_ready
);

  localparam int CNT_W = cnt_w(MAX_BURST);

  state_t             state;
  logic [SRC_W-1:0]   owner;
  logic [SRC_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;

  logic [NUM_REQ-1:0] own_mask;
  logic [NUM_REQ-1:0] pick_req;
  logic [SRC_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic               pipe_ready;
  logic               accept;
  logic [CNT_W-1:0]   cnt_next;
  logic               rel;
  logic [SRC_W-1:0]   nxt_ptr;
  logic [DATA_W-1:0]  beat_data;

  // While locked only the owner is eligible; the picker then just confirms it
  assign own_mask   = NUM_REQ'(1) << owner;
  assign pick_req   = (state == LOCKED) ? (req_valid & own_mask) : req_valid;
  assign pick_ptr   = (state == LOCKED) ? owner : rr_ptr;

  pass_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign pipe_ready = !out_valid || out_ready;
  assign req_ready  = grant & {NUM_REQ{pipe_ready}};
  assign accept     = pipe_ready && pick_any;

  assign cnt_next   = burst_cnt + CNT_W'(1);
  assign rel        = req_last[pick_idx] || (cnt_next == CNT_W'(MAX_BURST));
  assign nxt_ptr    = (pick_idx == SRC_W'(NUM_REQ - 1)) ? '0 : pick_idx + SRC_W'(1);
  assign beat_data  = req_data[pick_idx*DATA_W +: DATA_W];

  // Grant state: lock on a non-final beat, release and rotate on the final one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      if (rel) begin
        state     <= IDLE;
        rr_ptr    <= nxt_ptr;
        burst_cnt <= '0;
      end else begin
        state     <= LOCKED;
        owner     <= pick_idx;
        burst_cnt <= cnt_next;
      end
    end
  end

  // Output register: load on accept, drain when consumed, hold under backpressure
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_src   <= pick_idx;
      out_last  <= rel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pass_arbiter.sv
// Directed bench for pass_arbiter (4 requesters, 8-bit beats, MAX_BURST 8 and 1).
module tb_pass_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_last;
  logic        out_ready;

  logic [3:0]  req_ready1;
  logic        out_valid1;
  logic [7:0]  out_data1;
  logic [1:0]  out_src1;
  logic        out_last1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pass_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(8)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_last(out_last), .out_ready(out_ready)
  );

  // Same inputs, single-beat bursts: every output beat must be flagged last
  pass_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_src(out_src1), .out_last(out_last1), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] src, input logic [7:0] d,
                          input logic last);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_src"},   {30'd0, out_src},   {30'd0, src});
    chk({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
    chk({tag, "_last"},  {31'd0, out_last},  {31'd0, last});
  endtask

  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {28'd0, req_ready}, {28'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_src",   {30'd0, out_src},   32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    chk("rst_last",  {31'd0, out_last},  32'd0);
    chk("rst_state", {31'd0, dut.state}, 32'd0);
    chk("rst_ptr",   {30'd0, dut.rr_ptr}, 32'd0);
    chk("rst_cnt",   {28'd0, dut.burst_cnt}, 32'd0);
    reset_n = 1'b1;

    // Round robin: everyone valid with single-beat bursts
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk_rdy($sformatf("rr_rdy%0d", k), 4'(1 << (k % 4)));
      tick();
      chk_beat($sformatf("rr%0d", k), 2'(k % 4), 8'h10 + 8'(k % 4), 1'b1);
    end
    req_valid = '0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_data",  {24'd0, out_data},  32'h10);

    // Burst lock: requester 1 three beats while requester 0 waits (rr_ptr = 1)
    set_req(0, 1'b1, 8'hA0, 1'b1);
    set_req(1, 1'b1, 8'hB1, 1'b0);
    chk_rdy("lock_rdy1", 4'b0010);
    tick(); chk_beat("lock1", 2'd1, 8'hB1, 1'b0);
    set_req(1, 1'b1, 8'hB2, 1'b0);
    chk_rdy("lock_rdy2", 4'b0010);
    tick(); chk_beat("lock2", 2'd1, 8'hB2, 1'b0);
    set_req(1, 1'b1, 8'hB3, 1'b1);
    chk_rdy("lock_rdy3", 4'b0010);
    tick(); chk_beat("lock3", 2'd1, 8'hB3, 1'b1);
    set_req(1, 1'b0, 8'h00, 1'b0);
    chk_rdy("lock_rdy4", 4'b0001);
    tick(); chk_beat("lock4", 2'd0, 8'hA0, 1'b1);
    set_req(0, 1'b0, 8'h00, 1'b0);

    // Forced release at 8 beats: requester 3 never says last (rr_ptr = 1)
    set_req(0, 1'b1, 8'hA0, 1'b1);
    for (int b = 1; b <= 8; b++) begin
      set_req(3, 1'b1, 8'h30 + 8'(b), 1'b0);
      chk_rdy($sformatf("force_rdy%0d", b), 4'b1000);
      tick();
      chk_beat($sformatf("force%0d", b), 2'd3, 8'h30 + 8'(b), b == 8);
      chk($sformatf("mb1_last%0d", b), {30'd0, out_valid1, out_last1}, 32'd3);
    end
    chk_rdy("force_rdy_r0", 4'b0001);
    tick(); chk_beat("force_r0", 2'd0, 8'hA0, 1'b1);
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(3, 1'b1, 8'h39, 1'b0);
    chk_rdy("resume_rdy9", 4'b1000);
    tick(); chk_beat("resume9", 2'd3, 8'h39, 1'b0);
    set_req(3, 1'b1, 8'h3A, 1'b1);
    tick(); chk_beat("resume10", 2'd3, 8'h3A, 1'b1);
    set_req(3, 1'b0, 8'h00, 1'b0);

    // Backpressure (rr_ptr = 0): requester 1 wins, then stall 4 cycles
    set_req(1, 1'b1, 8'hC1, 1'b1);
    set_req(2, 1'b1, 8'hC2, 1'b1);
    tick(); chk_beat("bp_first", 2'd1, 8'hC1, 1'b1);
    set_req(1, 1'b0, 8'h00, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_rdy($sformatf("bp_rdy%0d", c), 4'b0000);
      tick();
      chk_beat($sformatf("bp_hold%0d", c), 2'd1, 8'hC1, 1'b1);
      chk($sformatf("bp_ptr%0d", c), {30'd0, dut.rr_ptr}, 32'd2);
    end
    out_ready = 1'b1;
    chk_rdy("bp_rdy_go", 4'b0100);
    tick(); chk_beat("bp_next", 2'd2, 8'hC2, 1'b1);
    set_req(2, 1'b0, 8'h00, 1'b0);
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Owner stall (rr_ptr = 3): requester 2 locks, then drops valid
    set_req(2, 1'b1, 8'hD1, 1'b0);
    chk_rdy("stall_rdy0", 4'b0100);
    tick(); chk_beat("stall_first", 2'd2, 8'hD1, 1'b0);
    set_req(2, 1'b0, 8'hD1, 1'b0);
    set_req(1, 1'b1, 8'hE1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk_rdy($sformatf("stall_rdy%0d", c + 1), 4'b0000);
      tick();
      chk($sformatf("stall_valid%0d", c), {31'd0, out_valid}, 32'd0);
    end
    set_req(2, 1'b1, 8'hD2, 1'b1);
    chk_rdy("stall_rdy_back", 4'b0100);
    tick(); chk_beat("stall_resume", 2'd2, 8'hD2, 1'b1);
    set_req(2, 1'b0, 8'h00, 1'b0);
    chk_rdy("stall_rdy_r1", 4'b0010);
    tick(); chk_beat("stall_r1", 2'd1, 8'hE1, 1'b1);
    set_req(1, 1'b0, 8'h00, 1'b0);

    // Reset mid-burst (rr_ptr = 2): requester 3 locks, then async reset
    set_req(3, 1'b1, 8'hF3, 1'b0);
    tick(); chk_beat("mid_first", 2'd3, 8'hF3, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_src",   {30'd0, out_src},   32'd0);
    chk("mid_rst_state", {31'd0, dut.state}, 32'd0);
    chk("mid_rst_ptr",   {30'd0, dut.rr_ptr}, 32'd0);
    set_req(3, 1'b0, 8'h00, 1'b0);
    tick();
    reset_n = 1'b1;
    set_req(2, 1'b1, 8'h22, 1'b1);
    chk_rdy("post_rst_rdy", 4'b0100);
    tick(); chk_beat("post_rst", 2'd2, 8'h22, 1'b1);
    set_req(2, 1'b0, 8'h00, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
